fthread_job_scheduler: RTL and testbench
========================================

# fthread_job_scheduler

Dispatches job command lines from the host-side command stream to a pool of `NUM_FTHREADS` fthread instances. Jobs are buffered in an in-order queue, issued head-of-line to any idle fthread with round-robin priority, and tracked busy until that fthread pulses `fthread_job_done`. Completions are reported upstream one per cycle, with the fthread index attached. The block sits between the command/MMIO front end and the fthread array. It does not touch the memory arbiter paths.

## Interface
- `NUM_FTHREADS`, 4: fthreads served, 1..16.
- `CMD_LINE_WIDTH`, 512: width of a job command line (`CMD_LINE_WIDTH` define).
- `QUEUE_DEPTH`, 8: job queue entries, power of two ≥ 2.
- `ID_W`, $clog2(NUM_FTHREADS) (min 1): fthread index width.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `job_valid` in 1: upstream job offered.
- `job_line` in CMD_LINE_WIDTH: job command line.
- `job_ready` out 1: queue can accept.
- `sched_enable` in 1: dispatch allowed when 1.
- `cmd_valid` out NUM_FTHREADS: one-hot, single-cycle dispatch strobe per fthread.
- `cmd_line` out CMD_LINE_WIDTH: registered command line, broadcast to all fthreads.
- `fthread_job_done` in NUM_FTHREADS: per-fthread completion pulse.
- `job_done_valid` out 1: completion report strobe.
- `job_done_id` out ID_W: index of the completed fthread.
- `busy` out NUM_FTHREADS: per-fthread busy vector.
- `all_idle` out 1: queue empty, no busy fthread, no pending report.
- `done_err` out 1: sticky; a done pulse arrived for a non-busy fthread.
- `jobs_dispatched` out 32: dispatch count, wraps.
- `jobs_completed` out 32: completion-report count, wraps.

## Operation
- Queue: circular FIFO with `QUEUE_DEPTH` entries.
  - Write when `job_valid & job_ready`.
  - `job_ready = (count != QUEUE_DEPTH)` is derived from registered count only and does not depend on `job_valid`.
  - Simultaneous write and dispatch-pop while full is not possible, because ready is low.
  - Simultaneous write and pop at any other level leaves count unchanged.
- Dispatch decision is combinational each cycle. Dispatch fires when `sched_enable` is high, count > 0, and some `busy[i]`=0.
  - Grantee: the first idle index at or after `rr_ptr`, searching upward modulo `NUM_FTHREADS`.
  - On fire: pop the head, set `busy[grant]`, and set `rr_ptr` ← grant+1 (mod N).
  - On the next edge, `cmd_valid` ← onehot(grant) and `cmd_line` ← head entry.
  - At most one dispatch per cycle.
- `cmd_valid` is 0 in every cycle without a dispatch. `cmd_line` holds its last value.
- Done handling:
  - `fthread_job_done[i]` with `busy[i]`=1 clears `busy[i]` and sets `pend[i]`.
  - `fthread_job_done[i]` with `busy[i]`=0 sets `done_err` and is otherwise ignored.
  - Several done bits in one cycle are all accepted.
- Report: when `pend` ≠ 0, `job_done_valid`=1 and `job_done_id` = lowest set index, both registered. That `pend` bit is cleared and `jobs_completed` increments.
- `busy[i]` cannot be set and cleared in the same cycle, because the decision uses registered busy. A done in cycle t makes fthread i eligible in cycle t+1.
- Counters increment by 1 per event and wrap 0xFFFFFFFF → 0.
- `sched_enable` low: the queue still accepts, and in-flight jobs still complete and report.

## Timing
- Reset (synchronous `rst`=1 at an edge) clears the following:
  - queue (flushed), `rr_ptr`, `busy`, `pend`, `cmd_valid`, `job_done_valid`, `done_err`, both counters;
  - `cmd_line` and `job_done_id` are set to 0;
  - `job_ready`=1 and `all_idle`=1 from the first cycle after reset.
- Reset mid-operation drops queued and in-flight jobs with no completion reports. The fthreads are reset by the same source.
- Latency: a job accepted at edge t into an empty queue with an idle fthread and enable high produces `cmd_valid` high in the cycle after edge t+1, i.e. 2 cycles.
- Done pulse at edge t → `job_done_valid` in the cycle after edge t+1 if no older pending reports exist. Otherwise one additional cycle per lower-indexed pending bit.
- `busy` and `job_ready` are registered outputs. `all_idle` is combinational from registered state.

## Test plan
- Reset, then one job (line = 0xA5..A5) with 4 idle fthreads → `cmd_valid`=0001 two cycles after acceptance, `cmd_line`=0xA5..A5, `busy`=0001, `jobs_dispatched`=1. Then pulse `fthread_job_done[0]` → `job_done_valid` with id 0 one cycle later, `busy`=0, `all_idle`=1.
- Burst of 6 jobs back-to-back, N=4, no dones → dispatch to fthreads 0,1,2,3 on consecutive cycles, 2 jobs remain queued. Done on fthread 2 → the 5th job goes to fthread 2. Round-robin check: `rr_ptr` was 0, so the first idle index at or after 0 is 2.
- Fill the queue: 8 jobs with `sched_enable`=0 → `job_ready` drops after the 8th, and a 9th `job_valid` is held off. Raising enable → `job_ready` returns one cycle after the first pop.
- Dones on fthreads 3 and 1 in the same cycle → reports id 1 then id 3 on consecutive cycles, `jobs_completed` +2.
- Done pulse on idle fthread 2 → `done_err`=1 and stays set, `busy` is unchanged, no report. Only reset clears it.
- Assert `rst` with 3 busy and 4 queued → next cycle `busy`=0, `job_ready`=1, `all_idle`=1, counters 0, no `cmd_valid` or `job_done_valid` afterwards.

Source files
------------

// File: rtl/fthread_job_scheduler.sv
// ---------------------------------------------------------------------------
// fthread_job_scheduler
//   Buffers job command lines in an in-order queue and hands them, head of
//   line, to any idle fthread. Among idle fthreads, the one chosen is the
//   first at or after a rotating pointer. Each fthread stays busy until it
//   pulses its done bit. Completions are reported upstream one per cycle,
//   lowest pending index first.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   job_valid_i/job_line_i  upstream job offer
//   job_ready_o             queue has room (from registered count)
//   sched_enable_i          dispatch allowed
//   cmd_valid_o/cmd_line_o  one-hot dispatch strobe, registered broadcast line
//   fthread_job_done_i      per-fthread completion pulse
//   job_done_valid_o/_id_o  registered completion report
//   busy_o                  per-fthread busy vector
//   all_idle_o              queue empty, nothing busy, no report pending
//   done_err_o              sticky: done seen on a non-busy fthread
//   jobs_dispatched_o       dispatch count (wraps)
//   jobs_completed_o        completion-report count (wraps)
// ---------------------------------------------------------------------------

// Per-fthread tracking: busy and pending-report bits for one fthread.
module fthread_job_scheduler_lane (
  input  logic clk_i,
  input  logic rst_i,
  input  logic grant_i,   // job dispatched to this fthread this cycle
  input  logic done_i,    // completion pulse from this fthread
  input  logic clr_i,     // pending report consumed this cycle
  output logic busy_o,
  output logic pend_o,
  output logic err_o      // done arrived while not busy
);
  logic busy_q, busy_d;
  logic pend_q, pend_d;

  // Grant only goes to a non-busy fthread and done only clears a busy one,
  // so set and clear of busy never coincide.
  assign busy_d = grant_i | (busy_q & ~done_i);
  // A new completion wins over the clear of an older one on the same lane.
  assign pend_d = (done_i & busy_q) | (pend_q & ~clr_i);
  assign err_o  = done_i & ~busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  assign busy_o = busy_q;
  assign pend_o = pend_q;
endmodule

module fthread_job_scheduler #(
  parameter int NUM_FTHREADS   = 4,
  parameter int CMD_LINE_WIDTH = 512,
  parameter int QUEUE_DEPTH    = 8,
  parameter int ID_W           = (NUM_FTHREADS > 1) ? $clog2(NUM_FTHREADS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      job_valid_i,
  input  logic [CMD_LINE_WIDTH-1:0] job_line_i,
  output logic                      job_ready_o,
  input  logic                      sched_enable_i,
  output logic [NUM_FTHREADS-1:0]   cmd_valid_o,
  output logic [CMD_LINE_WIDTH-1:0] cmd_line_o,
  input  logic [NUM_FTHREADS-1:0]   fthread_job_done_i,
  output logic                      job_done_valid_o,
  output logic [ID_W-1:0]           job_done_id_o,
  output logic [NUM_FTHREADS-1:0]   busy_o,
  output logic                      all_idle_o,
  output logic                      done_err_o,
  output logic [31:0]               jobs_dispatched_o,
  output logic [31:0]               jobs_completed_o
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  // ---------------- job queue ----------------
  logic [CMD_LINE_WIDTH-1:0] mem_q [QUEUE_DEPTH];
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      wr_en, pop;

  assign job_ready_o = (count_q != CW'(QUEUE_DEPTH));
  assign wr_en       = job_valid_i & job_ready_o;

  // ---------------- per-fthread state ----------------
  logic [NUM_FTHREADS-1:0] busy_w, pend_w, err_ev;
  logic [NUM_FTHREADS-1:0] grant_oh, clr_oh;

  fthread_job_scheduler_lane u_lane [NUM_FTHREADS-1:0] (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .grant_i (grant_oh),
    .done_i  (fthread_job_done_i),
    .clr_i   (clr_oh),
    .busy_o  (busy_w),
    .pend_o  (pend_w),
    .err_o   (err_ev)
  );

  // ---------------- round-robin grant ----------------
  // Pick the idle fthread with the smallest upward distance from rr_ptr.
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            fire;
  int              dist_c, best_c;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    best_c      = NUM_FTHREADS;
    dist_c      = 0;
    for (int i = 0; i < NUM_FTHREADS; i++) begin
      dist_c = i - int'(rr_ptr_q);
      if (dist_c < 0) dist_c = dist_c + NUM_FTHREADS;
      if (!busy_w[i] && (dist_c < best_c)) begin
        best_c      = dist_c;
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
  end

  assign fire = sched_enable_i & (count_q != '0) & grant_found;
  assign pop  = fire;

  always_comb begin
    grant_oh = '0;
    if (fire) grant_oh = NUM_FTHREADS'(1) << grant_idx;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fire) begin
      if (int'(grant_idx) == NUM_FTHREADS - 1) rr_ptr_d = '0;
      else                                     rr_ptr_d = grant_idx + ID_W'(1);
    end
  end

  // ---------------- completion report ----------------
  logic            rpt_any;
  logic [ID_W-1:0] rpt_idx;

  always_comb begin
    rpt_any = 1'b0;
    rpt_idx = '0;
    clr_oh  = '0;
    for (int i = 0; i < NUM_FTHREADS; i++) begin
      if (pend_w[i] && !rpt_any) begin
        rpt_any   = 1'b1;
        rpt_idx   = ID_W'(i);
        clr_oh[i] = 1'b1;
      end
    end
  end

  // ---------------- queue pointers ----------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; a reset flushes the queue through the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= job_line_i;
  end

  // ---------------- registered outputs ----------------
  logic [NUM_FTHREADS-1:0]   cmd_valid_q;
  logic [CMD_LINE_WIDTH-1:0] cmd_line_q;
  logic                      done_valid_q;
  logic [ID_W-1:0]           done_id_q;
  logic                      done_err_q;
  logic [31:0]               disp_cnt_q, comp_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rr_ptr_q     <= '0;
      cmd_valid_q  <= '0;
      cmd_line_q   <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_err_q   <= 1'b0;
      disp_cnt_q   <= '0;
      comp_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rr_ptr_q     <= rr_ptr_d;
      cmd_valid_q  <= grant_oh;
      if (fire) begin
        cmd_line_q <= mem_q[rd_ptr_q];
        disp_cnt_q <= disp_cnt_q + 32'd1;
      end
      done_valid_q <= rpt_any;
      if (rpt_any) begin
        done_id_q  <= rpt_idx;
        comp_cnt_q <= comp_cnt_q + 32'd1;
      end
      done_err_q   <= done_err_q | (|err_ev);
    end
  end

  assign cmd_valid_o       = cmd_valid_q;
  assign cmd_line_o        = cmd_line_q;
  assign job_done_valid_o  = done_valid_q;
  assign job_done_id_o     = done_id_q;
  assign busy_o            = busy_w;
  assign all_idle_o        = (count_q == '0) & ~(|busy_w) & ~(|pend_w);
  assign done_err_o        = done_err_q;
  assign jobs_dispatched_o = disp_cnt_q;
  assign jobs_completed_o  = comp_cnt_q;
endmodule

// File: tb/tb_fthread_job_scheduler.sv
module tb_fthread_job_scheduler;
  localparam int N  = 4;
  localparam int W  = 512;
  localparam int QD = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          job_valid = 1'b0;
  logic [W-1:0]  job_line = '0;
  logic          job_ready;
  logic          sched_enable = 1'b0;
  logic [N-1:0]  cmd_valid;
  logic [W-1:0]  cmd_line;
  logic [N-1:0]  fthread_job_done = '0;
  logic          job_done_valid;
  logic [IW-1:0] job_done_id;
  logic [N-1:0]  busy;
  logic          all_idle;
  logic          done_err;
  logic [31:0]   jobs_dispatched, jobs_completed;

  always #5 clk = ~clk;

  fthread_job_scheduler #(
    .NUM_FTHREADS(N), .CMD_LINE_WIDTH(W), .QUEUE_DEPTH(QD)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .job_valid_i(job_valid), .job_line_i(job_line), .job_ready_o(job_ready),
    .sched_enable_i(sched_enable),
    .cmd_valid_o(cmd_valid), .cmd_line_o(cmd_line),
    .fthread_job_done_i(fthread_job_done),
    .job_done_valid_o(job_done_valid), .job_done_id_o(job_done_id),
    .busy_o(busy), .all_idle_o(all_idle), .done_err_o(done_err),
    .jobs_dispatched_o(jobs_dispatched), .jobs_completed_o(jobs_completed)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_line(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (job-level view) ----------------
  logic [W-1:0] mq[$];      // queued job lines, oldest first
  bit           mb[N];      // fthread running a job
  bit           mp[N];      // completion waiting to be reported
  int           mrr;
  bit           merr;
  bit [31:0]    mdisp, mcomp;
  logic [N-1:0] mcv;
  logic [W-1:0] mline;
  bit           mdv;
  int           mid;

  function automatic logic [N-1:0] mbusy_vec();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = mb[i];
    return v;
  endfunction

  function automatic bit m_all_idle();
    bit r;
    r = (mq.size() == 0);
    for (int i = 0; i < N; i++) if (mb[i] || mp[i]) r = 0;
    return r;
  endfunction

  task automatic model_step(input bit r, input bit jv, input logic [W-1:0] ln,
                            input bit en, input logic [N-1:0] dn);
    bit acc;
    int lo;
    int g;
    int idx;
    if (r) begin
      mq.delete();
      for (int i = 0; i < N; i++) begin mb[i] = 0; mp[i] = 0; end
      mrr = 0; merr = 0; mdisp = 0; mcomp = 0;
      mcv = '0; mline = '0; mdv = 0; mid = 0;
      return;
    end
    acc = jv && (mq.size() < QD);
    // report the lowest completion that was already pending
    lo = -1;
    for (int i = 0; i < N; i++) if (mp[i] && lo < 0) lo = i;
    mdv = (lo >= 0);
    if (lo >= 0) begin mid = lo; mp[lo] = 0; mcomp++; end
    // choose a grantee from the fthreads idle before this edge
    g = -1;
    if (en && mq.size() > 0)
      for (int k = 0; k < N; k++) begin
        idx = (mrr + k) % N;
        if (g < 0 && !mb[idx]) g = idx;
      end
    for (int i = 0; i < N; i++)
      if (dn[i]) begin
        if (mb[i]) begin mb[i] = 0; mp[i] = 1; end
        else merr = 1;
      end
    mcv = '0;
    if (g >= 0) begin
      mcv[g] = 1'b1;
      mline  = mq.pop_front();
      mb[g]  = 1;
      mrr    = (g + 1) % N;
      mdisp++;
    end
    if (acc) mq.push_back(ln);
  endtask

  task automatic model_cmp();
    chk("cmd_valid", 64'(cmd_valid), 64'(mcv));
    chk_line("cmd_line", cmd_line, mline);
    chk("busy", 64'(busy), 64'(mbusy_vec()));
    chk("job_ready", 64'(job_ready), 64'(mq.size() != QD));
    chk("all_idle", 64'(all_idle), 64'(m_all_idle()));
    chk("done_err", 64'(done_err), 64'(merr));
    chk("job_done_valid", 64'(job_done_valid), 64'(mdv));
    chk("job_done_id", 64'(job_done_id), 64'(mid));
    chk("jobs_dispatched", 64'(jobs_dispatched), 64'(mdisp));
    chk("jobs_completed", 64'(jobs_completed), 64'(mcomp));
  endtask

  // drive inputs for one edge, advance the model, sample 1 time unit later
  task automatic cyc(input bit r, input bit jv, input logic [W-1:0] ln,
                     input bit en, input logic [N-1:0] dn);
    rst = r; job_valid = jv; job_line = ln; sched_enable = en; fthread_job_done = dn;
    @(posedge clk);
    model_step(r, jv, ln, en, dn);
    #1;
    model_cmp();
  endtask

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {64{b}};
  endfunction

  typedef struct {
    bit          rst, jv, en;
    logic [3:0]  dn;
    logic [7:0]  lb;
    logic [3:0]  ecv, ebusy;
    bit          erdy, eidle, edv;
    logic [1:0]  eid;
    logic [31:0] edisp, ecomp;
    logic [7:0]  elb;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] c0;
    logic [N-1:0] dn;

    // reset, one job, its completion
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 4'h0, 8'hA5, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd1, 32'd0, 8'hA5};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd1, 32'd0, 8'hA5};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 4'h1, 8'h00, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd1, 32'd0, 8'hA5};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 2'd0, 32'd1, 32'd1, 8'hA5};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd1, 32'd1, 8'hA5};

    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].rst, tbl[i].jv, rep(tbl[i].lb), tbl[i].en, tbl[i].dn);
      chk($sformatf("tbl%0d cmd_valid", i), 64'(cmd_valid), 64'(tbl[i].ecv));
      chk($sformatf("tbl%0d busy", i), 64'(busy), 64'(tbl[i].ebusy));
      chk($sformatf("tbl%0d job_ready", i), 64'(job_ready), 64'(tbl[i].erdy));
      chk($sformatf("tbl%0d all_idle", i), 64'(all_idle), 64'(tbl[i].eidle));
      chk($sformatf("tbl%0d done_valid", i), 64'(job_done_valid), 64'(tbl[i].edv));
      chk($sformatf("tbl%0d done_id", i), 64'(job_done_id), 64'(tbl[i].eid));
      chk($sformatf("tbl%0d dispatched", i), 64'(jobs_dispatched), 64'(tbl[i].edisp));
      chk($sformatf("tbl%0d completed", i), 64'(jobs_completed), 64'(tbl[i].ecomp));
      chk_line($sformatf("tbl%0d cmd_line", i), cmd_line, rep(tbl[i].elb));
    end

    // burst of 6, then a done on fthread 2 takes the 5th job
    cyc(1, 0, '0, 0, '0);
    for (int k = 0; k < 6; k++) cyc(0, 1, rep(8'(k + 1)), 1, '0);
    cyc(0, 0, '0, 1, '0);
    cyc(0, 0, '0, 1, '0);
    chk("burst busy all", 64'(busy), 64'hF);
    chk("burst dispatched", 64'(jobs_dispatched), 64'd4);
    cyc(0, 0, '0, 1, 4'b0100);
    cyc(0, 0, '0, 1, '0);
    chk("rr grant fthread2", 64'(cmd_valid), 64'h4);
    chk_line("rr job5 line", cmd_line, rep(8'h05));

    // fill with dispatch disabled, ninth offer held off
    cyc(1, 0, '0, 0, '0);
    for (int k = 0; k < 8; k++) cyc(0, 1, rep(8'(8'h20 + k)), 0, '0);
    chk("full ready low", 64'(job_ready), 64'd0);
    cyc(0, 1, rep(8'hEE), 0, '0);
    chk("ninth held off", 64'(job_ready), 64'd0);
    cyc(0, 0, '0, 1, '0);
    chk("ready after pop", 64'(job_ready), 64'd1);
    chk("first pop grant", 64'(cmd_valid), 64'h1);
    chk_line("first pop line", cmd_line, rep(8'h20));

    // two dones in one cycle report lowest first
    cyc(1, 0, '0, 0, '0);
    for (int k = 0; k < 4; k++) cyc(0, 1, rep(8'(8'h40 + k)), 1, '0);
    cyc(0, 0, '0, 1, '0);
    cyc(0, 0, '0, 1, '0);
    c0 = jobs_completed;
    cyc(0, 0, '0, 1, 4'b1010);
    cyc(0, 0, '0, 1, '0);
    chk("dual report1 valid", 64'(job_done_valid), 64'd1);
    chk("dual report1 id", 64'(job_done_id), 64'd1);
    cyc(0, 0, '0, 1, '0);
    chk("dual report2 valid", 64'(job_done_valid), 64'd1);
    chk("dual report2 id", 64'(job_done_id), 64'd3);
    chk("dual completed +2", 64'(jobs_completed), 64'(c0 + 32'd2));

    // done on an idle fthread is flagged and sticks
    cyc(0, 0, '0, 1, 4'b0100);
    cyc(0, 0, '0, 1, '0);
    cyc(0, 0, '0, 1, '0);
    chk("pre err clear", 64'(done_err), 64'd0);
    cyc(0, 0, '0, 1, 4'b0100);
    chk("err set", 64'(done_err), 64'd1);
    chk("err busy same", 64'(busy), 64'h1);
    cyc(0, 0, '0, 1, '0);
    chk("err no report", 64'(job_done_valid), 64'd0);
    for (int k = 0; k < 3; k++) cyc(0, 0, '0, 1, '0);
    chk("err sticky", 64'(done_err), 64'd1);

    // reset with three busy and four queued
    cyc(1, 0, '0, 0, '0);
    for (int k = 0; k < 7; k++) cyc(0, 1, rep(8'(8'h60 + k)), 0, '0);
    for (int k = 0; k < 3; k++) cyc(0, 0, '0, 1, '0);
    chk("pre-reset busy", 64'(busy), 64'h7);
    cyc(1, 0, '0, 1, '0);
    chk("rst busy", 64'(busy), 64'h0);
    chk("rst ready", 64'(job_ready), 64'd1);
    chk("rst all_idle", 64'(all_idle), 64'd1);
    chk("rst dispatched", 64'(jobs_dispatched), 64'd0);
    chk("rst completed", 64'(jobs_completed), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, '0, 1, '0);
      chk("post-rst cmd_valid", 64'(cmd_valid), 64'd0);
      chk("post-rst done_valid", 64'(job_done_valid), 64'd0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      dn = N'($urandom) & mbusy_vec() & N'($urandom);
      if ($urandom_range(0, 39) == 0) dn = N'($urandom);
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1,
          {16{$urandom}}, $urandom_range(0, 3) != 0, dn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
